hazard_forward_unit: RTL and testbench

//  Detects and resolves pipeline hazards for the 5-stage MIPS core. Keeps a shadow copy of the

---
 rtl/hazard_forward_unit.sv | 146 ++++++++++++++
 tb/tb_hazard_forward_unit.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_forward_unit.sv
// Hazard detection and operand-forwarding unit for the 5-stage MIPS pipeline.
// It keeps a shadow copy of the EX/MEM/WB destination fields and drives the stall, flush and forward controls.
module hazard_forward_unit #(
    parameter int REG_AW = 5,
    parameter bit FWD_WB = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic [REG_AW-1:0] id_dst,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic              branch_taken,
    input  logic              ext_hold,
    output logic              risk_sig,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              ifid_flush,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b
);

    // A stage produces r only when it holds a live register write; $0 never matches.
    function automatic logic writes_reg(input logic valid, input logic regwrite,
                                        input logic [REG_AW-1:0] dst, input logic [REG_AW-1:0] r);
        return valid & regwrite & (dst == r) & (r != {REG_AW{1'b0}});
    endfunction

    logic              ex_valid_r, ex_regwrite_r, ex_memread_r, ex_use_rs_r, ex_use_rt_r;
    logic [REG_AW-1:0] ex_dst_r, ex_rs_r, ex_rt_r;
    logic              mem_valid_r, mem_regwrite_r;
    logic [REG_AW-1:0] mem_dst_r;
    logic              wb_valid_r, wb_regwrite_r;
    logic [REG_AW-1:0] wb_dst_r;

    logic mem_hit_a_s, mem_hit_b_s, wb_hit_a_s, wb_hit_b_s;
    logic rs_ex_s, rt_ex_s, rs_mem_s, rt_mem_s;
    logic luse_s, nofwd_stall_s, stall_s, bubble_s;

    assign mem_hit_a_s = ex_use_rs_r & writes_reg(mem_valid_r, mem_regwrite_r, mem_dst_r, ex_rs_r);
    assign mem_hit_b_s = ex_use_rt_r & writes_reg(mem_valid_r, mem_regwrite_r, mem_dst_r, ex_rt_r);
    assign wb_hit_a_s  = ex_use_rs_r & writes_reg(wb_valid_r, wb_regwrite_r, wb_dst_r, ex_rs_r);
    assign wb_hit_b_s  = ex_use_rt_r & writes_reg(wb_valid_r, wb_regwrite_r, wb_dst_r, ex_rt_r);

    assign rs_ex_s  = id_use_rs & writes_reg(ex_valid_r, ex_regwrite_r, ex_dst_r, id_rs);
    assign rt_ex_s  = id_use_rt & writes_reg(ex_valid_r, ex_regwrite_r, ex_dst_r, id_rt);
    assign rs_mem_s = id_use_rs & writes_reg(mem_valid_r, mem_regwrite_r, mem_dst_r, id_rs);
    assign rt_mem_s = id_use_rt & writes_reg(mem_valid_r, mem_regwrite_r, mem_dst_r, id_rt);

    // Without MEM/WB forwarding, any in-flight producer of a used source must be waited out.
    assign luse_s        = ex_memread_r & (rs_ex_s | rt_ex_s);
    assign nofwd_stall_s = (FWD_WB == 1'b0) & (rs_ex_s | rt_ex_s | rs_mem_s | rt_mem_s);
    assign stall_s       = luse_s | nofwd_stall_s;
    assign bubble_s      = branch_taken | stall_s;

    // Operand select for the instruction in EX; the newer MEM result wins over WB.
    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (mem_hit_a_s) begin
            fwd_a = 2'b01;
        end else if ((FWD_WB == 1'b1) && wb_hit_a_s) begin
            fwd_a = 2'b10;
        end else begin
            fwd_a = 2'b00;
        end
        if (mem_hit_b_s) begin
            fwd_b = 2'b01;
        end else if ((FWD_WB == 1'b1) && wb_hit_b_s) begin
            fwd_b = 2'b10;
        end else begin
            fwd_b = 2'b00;
        end
    end

    // Pipeline control strobes, highest-priority cause first.
    always_comb begin
        risk_sig   = 1'b0;
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        ifid_flush = 1'b0;
        if (ext_hold) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
        end else if (branch_taken) begin
            risk_sig   = 1'b1;
            ifid_flush = 1'b1;
        end else if (stall_s) begin
            risk_sig   = 1'b1;
            pc_write   = 1'b0;
            ifid_write = 1'b0;
        end else begin
            risk_sig   = 1'b0;
        end
    end

    // Shadow pipeline: advance unless frozen, inserting a bubble on branch or stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_r     <= 1'b0;
            ex_regwrite_r  <= 1'b0;
            ex_memread_r   <= 1'b0;
            ex_use_rs_r    <= 1'b0;
            ex_use_rt_r    <= 1'b0;
            ex_dst_r       <= {REG_AW{1'b0}};
            ex_rs_r        <= {REG_AW{1'b0}};
            ex_rt_r        <= {REG_AW{1'b0}};
            mem_valid_r    <= 1'b0;
            mem_regwrite_r <= 1'b0;
            mem_dst_r      <= {REG_AW{1'b0}};
            wb_valid_r     <= 1'b0;
            wb_regwrite_r  <= 1'b0;
            wb_dst_r       <= {REG_AW{1'b0}};
        end else if (!ext_hold) begin
            wb_valid_r     <= mem_valid_r;
            wb_regwrite_r  <= mem_regwrite_r;
            wb_dst_r       <= mem_dst_r;
            mem_valid_r    <= ex_valid_r;
            mem_regwrite_r <= ex_regwrite_r;
            mem_dst_r      <= ex_dst_r;
            if (bubble_s) begin
                ex_valid_r    <= 1'b0;
                ex_regwrite_r <= 1'b0;
                ex_memread_r  <= 1'b0;
                ex_use_rs_r   <= 1'b0;
                ex_use_rt_r   <= 1'b0;
                ex_dst_r      <= {REG_AW{1'b0}};
                ex_rs_r       <= {REG_AW{1'b0}};
                ex_rt_r       <= {REG_AW{1'b0}};
            end else begin
                ex_valid_r    <= 1'b1;
                ex_regwrite_r <= id_regwrite;
                ex_memread_r  <= id_memread;
                ex_use_rs_r   <= id_use_rs;
                ex_use_rt_r   <= id_use_rt;
                ex_dst_r      <= id_dst;
                ex_rs_r       <= id_rs;
                ex_rt_r       <= id_rt;
            end
        end
    end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Randomized scoreboard bench for hazard_forward_unit, run with MEM/WB forwarding on and off.
// A stage-list reference model predicts outputs; a negedge monitor pops and compares them.
module tb_hazard_forward_unit;

    typedef struct packed {
        logic       v;
        logic       rw;
        logic       mr;
        logic [4:0] dst;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       urs;
        logic       urt;
    } ent_t;

    typedef struct packed {
        logic       risk;
        logic       pcw;
        logic       ifw;
        logic       flush;
        logic [1:0] fa;
        logic [1:0] fb;
    } out_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs, id_rt, id_dst;
    logic       id_use_rs, id_use_rt, id_regwrite, id_memread, branch_taken, ext_hold;
    logic       risk1, pcw1, ifw1, fl1, risk0, pcw0, ifw0, fl0;
    logic [1:0] fa1, fb1, fa0, fb0;

    int checks   = 0;
    int failures = 0;
    out_t exp_q1[$];
    out_t exp_q0[$];
    ent_t p1[3];   // reference pipeline with forwarding: index 0 = EX, 1 = MEM, 2 = WB
    ent_t p0[3];   // reference pipeline without MEM/WB forwarding
    bit   done = 1'b0;

    always #5 clk = ~clk;

    hazard_forward_unit #(.REG_AW(5), .FWD_WB(1'b1)) dut (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs),
        .id_use_rt(id_use_rt), .id_dst(id_dst), .id_regwrite(id_regwrite), .id_memread(id_memread),
        .branch_taken(branch_taken), .ext_hold(ext_hold), .risk_sig(risk1), .pc_write(pcw1),
        .ifid_write(ifw1), .ifid_flush(fl1), .fwd_a(fa1), .fwd_b(fb1)
    );

    hazard_forward_unit #(.REG_AW(5), .FWD_WB(1'b0)) dut_nf (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs),
        .id_use_rt(id_use_rt), .id_dst(id_dst), .id_regwrite(id_regwrite), .id_memread(id_memread),
        .branch_taken(branch_taken), .ext_hold(ext_hold), .risk_sig(risk0), .pc_write(pcw0),
        .ifid_write(ifw0), .ifid_flush(fl0), .fwd_a(fa0), .fwd_b(fb0)
    );

    function automatic bit produces(ent_t e, logic [4:0] r);
        return e.v && e.rw && (e.dst == r) && (r != 5'd0);
    endfunction

    function automatic logic [1:0] pick(ent_t ex, ent_t mem, ent_t wb, bit operand_b, bit fwb);
        logic [4:0] r;
        bit u;
        r = operand_b ? ex.rt : ex.rs;
        u = operand_b ? ex.urt : ex.urs;
        if (u && produces(mem, r)) return 2'd1;
        if (u && fwb && produces(wb, r)) return 2'd2;
        return 2'd0;
    endfunction

    function automatic bit must_stall(ent_t ex, ent_t mem, bit fwb);
        bit ex_a, ex_b, mem_a, mem_b;
        ex_a  = id_use_rs && produces(ex, id_rs);
        ex_b  = id_use_rt && produces(ex, id_rt);
        mem_a = id_use_rs && produces(mem, id_rs);
        mem_b = id_use_rt && produces(mem, id_rt);
        if (ex.mr && (ex_a || ex_b)) return 1'b1;
        return !fwb && (ex_a || ex_b || mem_a || mem_b);
    endfunction

    function automatic out_t predict(ent_t ex, ent_t mem, ent_t wb, bit fwb);
        out_t o;
        o.fa = pick(ex, mem, wb, 1'b0, fwb);
        o.fb = pick(ex, mem, wb, 1'b1, fwb);
        if (ext_hold)                         {o.risk, o.pcw, o.ifw, o.flush} = 4'b0000;
        else if (branch_taken)                {o.risk, o.pcw, o.ifw, o.flush} = 4'b1111;
        else if (must_stall(ex, mem, fwb))    {o.risk, o.pcw, o.ifw, o.flush} = 4'b1000;
        else                                  {o.risk, o.pcw, o.ifw, o.flush} = 4'b0110;
        return o;
    endfunction

    function automatic ent_t id_entry();
        ent_t e;
        e.v = 1'b1; e.rw = id_regwrite; e.mr = id_memread; e.dst = id_dst;
        e.rs = id_rs; e.rt = id_rt; e.urs = id_use_rs; e.urt = id_use_rt;
        return e;
    endfunction

    task automatic check(input string name, input int inst, input logic [1:0] got, input logic [1:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s fwd_wb=%0d at %0t: got=%0d expected=%0d", name, inst, $time, got, want);
        end
    endtask

    // Monitor: one expected response per cycle, compared away from the rising edge.
    initial begin
        out_t e;
        forever begin
            @(negedge clk);
            if (exp_q1.size() > 0) begin
                e = exp_q1.pop_front();
                check("risk_sig", 1, {1'b0, risk1}, {1'b0, e.risk});
                check("pc_write", 1, {1'b0, pcw1}, {1'b0, e.pcw});
                check("ifid_write", 1, {1'b0, ifw1}, {1'b0, e.ifw});
                check("ifid_flush", 1, {1'b0, fl1}, {1'b0, e.flush});
                check("fwd_a", 1, fa1, e.fa);
                check("fwd_b", 1, fb1, e.fb);
            end
            if (exp_q0.size() > 0) begin
                e = exp_q0.pop_front();
                check("risk_sig", 0, {1'b0, risk0}, {1'b0, e.risk});
                check("pc_write", 0, {1'b0, pcw0}, {1'b0, e.pcw});
                check("ifid_write", 0, {1'b0, ifw0}, {1'b0, e.ifw});
                check("ifid_flush", 0, {1'b0, fl0}, {1'b0, e.flush});
                check("fwd_a", 0, fa0, e.fa);
                check("fwd_b", 0, fb0, e.fb);
            end
        end
    end

    // Apply one cycle of stimulus: predict, enqueue, then step the reference pipelines.
    task automatic issue();
        bit s1, s0;
        exp_q1.push_back(predict(p1[0], p1[1], p1[2], 1'b1));
        exp_q0.push_back(predict(p0[0], p0[1], p0[2], 1'b0));
        s1 = must_stall(p1[0], p1[1], 1'b1);
        s0 = must_stall(p0[0], p0[1], 1'b0);
        if (rst) begin
            for (int i = 0; i < 3; i++) begin p1[i] = '0; p0[i] = '0; end
        end else if (!ext_hold) begin
            p1[2] = p1[1]; p1[1] = p1[0];
            p1[0] = (branch_taken || s1) ? ent_t'(0) : id_entry();
            p0[2] = p0[1]; p0[1] = p0[0];
            p0[0] = (branch_taken || s0) ? ent_t'(0) : id_entry();
        end
    endtask

    initial begin
        int hold_left;
        rst = 1'b1; branch_taken = 1'b0; ext_hold = 1'b0;
        id_rs = 5'd0; id_rt = 5'd0; id_dst = 5'd0;
        id_use_rs = 1'b0; id_use_rt = 1'b0; id_regwrite = 1'b0; id_memread = 1'b0;
        for (int i = 0; i < 3; i++) begin p1[i] = '0; p0[i] = '0; end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        issue();   // idle cycle straight after reset: the reset-state outputs
        hold_left = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(posedge clk);
            #1;
            id_rs       = 5'($urandom_range(0, 3));
            id_rt       = 5'($urandom_range(0, 3));
            id_dst      = 5'($urandom_range(0, 3));
            id_use_rs   = ($urandom_range(0, 3) != 0);
            id_use_rt   = ($urandom_range(0, 3) != 0);
            id_regwrite = ($urandom_range(0, 3) != 0);
            id_memread  = ($urandom_range(0, 2) == 0);
            branch_taken = ($urandom_range(0, 7) == 0);
            if (hold_left == 0 && $urandom_range(0, 15) == 0) hold_left = $urandom_range(1, 3);
            ext_hold = (hold_left > 0);
            if (hold_left > 0) hold_left--;
            rst = ($urandom_range(0, 63) == 0);
            issue();
        end
        @(posedge clk);
        #1;
        rst = 1'b0; ext_hold = 1'b0; branch_taken = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q1.size() != 0 || exp_q0.size() != 0) begin
            failures++;
            $display("FAIL drain: got=%0d/%0d pending expected=0", exp_q1.size(), exp_q0.size());
        end
        done = 1'b1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Time bound so the run always ends.
    initial begin
        #500000;
        if (!done) begin
            $display("FAIL timeout: got=running expected=finished");
            $fatal(1, "timeout");
        end
    end

endmodule
